// File: rtl/demux_1_4_stream_if.sv
// demux_1_4_stream_if: one valid/ready input stream and a one-hot four-channel output stream
interface demux_1_4_stream_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  modport master (
    output in_data, in_sel, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );
  modport slave (
    input  in_data, in_sel, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: registered 1:4 stream demux with optional per-packet destination lock
module demux_1_4_stream #(
  parameter int WIDTH       = 4,
  parameter int LOCK_PACKET = 1
) (
  input logic            clk,
  input logic            rst,
  demux_1_4_stream_if.slave s
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           state, state_nxt;
  logic             full;
  logic [1:0]       dest;
  logic [1:0]       lock_sel;
  logic [1:0]       route;
  logic [WIDTH-1:0] data;
  logic             last;
  logic             drain;
  logic             accept;
  assign drain       = full && s.out_ready[dest];
  assign s.in_ready  = !full || drain;
  assign accept      = s.in_valid && s.in_ready;
  assign route       = (LOCK_PACKET != 0 && state == LOCKED) ? lock_sel : s.in_sel;
  assign s.out_valid = full ? (4'b0001 << dest) : 4'b0000;
  assign s.out_data  = data;
  assign s.out_last  = last;
  // lock on the first beat of a multi-beat packet, release on its last beat
  always_comb begin
    state_nxt = state;
    if (LOCK_PACKET != 0 && accept) state_nxt = s.in_last ? IDLE : LOCKED;
  end
  // packet lock state and the channel captured on the packet's first beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= 2'd0;
    end else begin
      state    <= state_nxt;
      lock_sel <= (state == IDLE && accept) ? s.in_sel : lock_sel;
    end
  end
  // single holding stage: load on accept, empty on a drain with nothing new behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dest <= 2'd0;
      data <= '0;
      last <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
      dest <= route;
      data <= s.in_data;
      last <= s.in_last;
    end else if (drain) begin
      full <= 1'b0;
    end
  end
endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb_demux_1_4_stream: directed and random checks of both lock modes against a packet-level model
module tb_demux_1_4_stream;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] out_ready = 4'b1111;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  demux_1_4_stream_if #(.WIDTH(4)) i0 ();
  demux_1_4_stream_if #(.WIDTH(4)) i1 ();
  assign i0.in_data = in_data;
  assign i0.in_sel = in_sel;
  assign i0.in_last = in_last;
  assign i0.in_valid = in_valid;
  assign i0.out_ready = out_ready;
  assign i1.in_data = in_data;
  assign i1.in_sel = in_sel;
  assign i1.in_last = in_last;
  assign i1.in_valid = in_valid;
  assign i1.out_ready = out_ready;
  demux_1_4_stream #(.WIDTH(4), .LOCK_PACKET(0)) dut0 (.clk(clk), .rst(rst), .s(i0.slave));
  demux_1_4_stream #(.WIDTH(4), .LOCK_PACKET(1)) dut1 (.clk(clk), .rst(rst), .s(i1.slave));
  logic [3:0] ov [2];
  logic [3:0] od [2];
  logic       ol [2];
  logic       ir [2];
  assign ov[0] = i0.out_valid;
  assign ov[1] = i1.out_valid;
  assign od[0] = i0.out_data;
  assign od[1] = i1.out_data;
  assign ol[0] = i0.out_last;
  assign ol[1] = i1.out_last;
  assign ir[0] = i0.in_ready;
  assign ir[1] = i1.in_ready;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // packet-level model per DUT (index = LOCK_PACKET): pending beat and open-packet channel
  typedef struct packed {logic [1:0] ch; logic [3:0] d; logic l;} beat_t;
  beat_t pend [2][$];
  logic  in_pkt [2] = '{1'b0, 1'b0};
  logic [1:0] pkt_ch [2] = '{2'd0, 2'd0};
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k].delete();
        in_pkt[k] = 1'b0;
      end else begin
        logic exp_rdy;
        logic [1:0] ch;
        exp_rdy = (pend[k].size() == 0) || out_ready[pend[k][0].ch];
        chk($sformatf("in_ready[%0d]", k), {31'd0, ir[k]}, {31'd0, exp_rdy});
        chk($sformatf("out_valid[%0d]", k), {28'd0, ov[k]},
            pend[k].size() != 0 ? 32'd1 << pend[k][0].ch : 32'd0);
        if (pend[k].size() != 0) begin
          chk($sformatf("out_data[%0d]", k), {28'd0, od[k]}, {28'd0, pend[k][0].d});
          chk($sformatf("out_last[%0d]", k), {31'd0, ol[k]}, {31'd0, pend[k][0].l});
          if (out_ready[pend[k][0].ch]) void'(pend[k].pop_front());
        end
        if (in_valid && exp_rdy) begin
          ch = (k == 1 && in_pkt[k]) ? pkt_ch[k] : in_sel;
          pend[k].push_back('{ch, in_data, in_last});
          if (k == 1 && !in_pkt[k] && !in_last) begin
            in_pkt[k] = 1'b1;
            pkt_ch[k] = in_sel;
          end else if (in_last) in_pkt[k] = 1'b0;
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [3:0] d, input logic [1:0] sl, input logic l);
    in_valid = 1'b1;
    in_data = d;
    in_sel = sl;
    in_last = l;
  endtask
  initial begin
    logic [3:0] s1d [4] = '{4'h3, 4'h5, 4'h9, 4'hC};
    logic [3:0] exp_l [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000};
    logic [3:0] exp_n [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b1000};
    logic [1:0] s3s [4] = '{2'd1, 2'd3, 2'd0, 2'd3};
    logic       s3l [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("reset out_valid", {28'd0, ov[1]}, 32'd0);
    chk("reset out_data", {28'd0, od[1]}, 32'd0);
    chk("reset out_last", {31'd0, ol[1]}, 32'd0);
    chk("reset in_ready", {31'd0, ir[1]}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      beat(s1d[i], i[1:0], 1'b1);
      cyc();
      chk("s1 out_valid", {28'd0, ov[1]}, 32'd1 << i);
      chk("s1 out_data", {28'd0, od[1]}, {28'd0, s1d[i]});
      chk("s1 in_ready", {31'd0, ir[1]}, 32'd1);
    end
    in_valid = 1'b0;
    cyc();
    out_ready = 4'b1011;
    beat(4'hA, 2'd2, 1'b1);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("s2 out_valid", {28'd0, ov[1]}, 32'h4);
      chk("s2 out_data", {28'd0, od[1]}, 32'hA);
      chk("s2 in_ready", {31'd0, ir[1]}, 32'd0);
      if (i < 2) cyc();
    end
    out_ready = 4'b1111;
    #1;
    chk("s2 in_ready after release", {31'd0, ir[1]}, 32'd1);
    cyc();
    chk("s2 drained", {28'd0, ov[1]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      beat(4'(i + 1), s3s[i], s3l[i]);
      cyc();
      chk("s3 locked channel", {28'd0, ov[1]}, {28'd0, exp_l[i]});
      chk("s4 unlocked channel", {28'd0, ov[0]}, {28'd0, exp_n[i]});
    end
    in_valid = 1'b0;
    cyc();
    out_ready = 4'b1110;
    beat(4'h5, 2'd0, 1'b1);
    cyc();
    beat(4'h6, 2'd2, 1'b1);
    #1;
    chk("s5 hol in_ready", {31'd0, ir[1]}, 32'd0);
    cyc();
    chk("s5 ch0 still held", {28'd0, ov[1]}, 32'h1);
    chk("s5 data held", {28'd0, od[1]}, 32'h5);
    out_ready = 4'b1111;
    cyc();
    chk("s5 ch2 after drain", {28'd0, ov[1]}, 32'h4);
    chk("s5 data", {28'd0, od[1]}, 32'h6);
    in_valid = 1'b0;
    cyc();
    beat(4'h7, 2'd1, 1'b0);
    cyc();
    in_valid = 1'b0;
    out_ready = 4'b0000;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("s6 out_valid after rst", {28'd0, ov[1]}, 32'd0);
    chk("s6 in_ready after rst", {31'd0, ir[1]}, 32'd1);
    out_ready = 4'b1111;
    beat(4'h8, 2'd3, 1'b1);
    cyc();
    chk("s6 routes by own sel", {28'd0, ov[1]}, 32'h8);
    chk("s6 data", {28'd0, od[1]}, 32'h8);
    in_valid = 1'b0;
    cyc();
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 4'($urandom);
      in_sel = 2'($urandom);
      in_last = ($urandom_range(0, 2) == 0);
      out_ready = 4'($urandom) | ($urandom_range(0, 1) ? 4'b1111 : 4'b0000);
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    cyc();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
